// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: shares a single downstream memory read/write port among
// NUM_CONSUMERS dcache miss requesters. The grant is round-robin and only one
// downstream transaction is outstanding at a time.
//
// Ports:
//   clk, reset                  - clock; synchronous active-low reset
//   consumer_read_valid/address - per-consumer read request (flat vectors)
//   consumer_read_ready/data    - per-consumer read completion and returned data
//   consumer_write_valid/address/data - per-consumer write request
//   consumer_write_ready        - per-consumer write completion
//   mem_read_*                  - downstream read channel
//   mem_write_*                 - downstream write channel
module dcache_mem_arbiter #(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned NUM_CONSUMERS = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
   output logic                                 mem_read_valid,
   output logic [ADDR_BITS-1:0]                 mem_read_address,
   input  logic                                 mem_read_ready,
   input  logic [DATA_BITS-1:0]                 mem_read_data,
   output logic                                 mem_write_valid,
   output logic [ADDR_BITS-1:0]                 mem_write_address,
   output logic [DATA_BITS-1:0]                 mem_write_data,
   input  logic                                 mem_write_ready
);

   localparam int unsigned PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

   state_t                   r_state, w_state_nxt;
   logic [PTR_W-1:0]         r_rr_ptr, w_rr_nxt;
   logic [PTR_W-1:0]         r_gnt_idx, w_idx_nxt;
   logic                     r_is_write, w_is_write_nxt;
   logic [ADDR_BITS-1:0]     r_addr, w_addr_nxt;
   logic [DATA_BITS-1:0]     r_wdata, w_wdata_nxt;
   logic [DATA_BITS-1:0]     r_rdata, w_rdata_nxt;
   logic [NUM_CONSUMERS-1:0] w_req;
   logic                     w_found;
   logic [PTR_W-1:0]         w_sel;
   logic                     w_relay_valid;
   logic [NUM_CONSUMERS-1:0]           w_crd_rdy_nxt, w_cwr_rdy_nxt;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] w_crd_data_nxt;

   logic [ADDR_BITS-1:0] w_rd_addr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0] w_wr_addr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0] w_wr_data [NUM_CONSUMERS];

   // (base + off) mod NUM_CONSUMERS, for off < NUM_CONSUMERS
   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
      return PTR_W'(s);
   endfunction

   // Unpack flat per-consumer buses
   for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_unpack
      assign w_rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
   end

   assign w_req = consumer_read_valid | consumer_write_valid;

   // Round-robin search: first requester at or after r_rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
         if (!w_found && w_req[rr_idx(r_rr_ptr, k)]) begin
            w_found = 1'b1;
            w_sel   = rr_idx(r_rr_ptr, k);
         end
      end
   end

   // Next-state and latched-register update
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_nxt       = r_rr_ptr;
      w_idx_nxt      = r_gnt_idx;
      w_is_write_nxt = r_is_write;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_rdata_nxt    = r_rdata;
      w_relay_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               // a consumer with both valids set gets its read first
               w_idx_nxt      = w_sel;
               w_rr_nxt       = rr_idx(w_sel, 1);
               w_is_write_nxt = !consumer_read_valid[w_sel];
               w_addr_nxt     = consumer_read_valid[w_sel] ? w_rd_addr[w_sel] : w_wr_addr[w_sel];
               w_wdata_nxt    = w_wr_data[w_sel];
               w_state_nxt    = consumer_read_valid[w_sel] ? READ_WAIT : WRITE_WAIT;
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               w_rdata_nxt = mem_read_data;
               w_state_nxt = RELAY;
            end
         end
         WRITE_WAIT: begin
            if (mem_write_ready) w_state_nxt = RELAY;
         end
         RELAY: begin
            // hold completion until the granted consumer withdraws its request
            w_relay_valid = r_is_write ? consumer_write_valid[r_gnt_idx]
                                       : consumer_read_valid[r_gnt_idx];
            if (!w_relay_valid) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Consumer-side outputs for the upcoming cycle
   always_comb begin
      w_crd_rdy_nxt  = '0;
      w_cwr_rdy_nxt  = '0;
      w_crd_data_nxt = '0;
      if (w_state_nxt == RELAY) begin
         for (int unsigned g = 0; g < NUM_CONSUMERS; g++) begin
            if (w_idx_nxt == PTR_W'(g)) begin
               if (w_is_write_nxt) begin
                  w_cwr_rdy_nxt[g] = 1'b1;
               end else begin
                  w_crd_rdy_nxt[g] = 1'b1;
                  w_crd_data_nxt[g*DATA_BITS +: DATA_BITS] = w_rdata_nxt;
               end
            end
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state             <= IDLE;
         r_rr_ptr            <= '0;
         r_gnt_idx           <= '0;
         r_is_write          <= 1'b0;
         r_addr              <= '0;
         r_wdata             <= '0;
         r_rdata             <= '0;
         mem_read_valid      <= 1'b0;
         mem_write_valid     <= 1'b0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
      end else begin
         r_state             <= w_state_nxt;
         r_rr_ptr            <= w_rr_nxt;
         r_gnt_idx           <= w_idx_nxt;
         r_is_write          <= w_is_write_nxt;
         r_addr              <= w_addr_nxt;
         r_wdata             <= w_wdata_nxt;
         r_rdata             <= w_rdata_nxt;
         mem_read_valid      <= (w_state_nxt == READ_WAIT);
         mem_write_valid     <= (w_state_nxt == WRITE_WAIT);
         consumer_read_ready  <= w_crd_rdy_nxt;
         consumer_write_ready <= w_cwr_rdy_nxt;
         consumer_read_data   <= w_crd_data_nxt;
      end
   end

   assign mem_read_address  = r_addr;
   assign mem_write_address = r_addr;
   assign mem_write_data    = r_wdata;

endmodule

// File: doc/dcache_mem_arbiter.md
DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data word width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, meaning number of dcache miss requesters sharing one memory port.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset (reset==0 sampled at clk rising edge resets the block).
REQ-006 SHALL have port consumer_read_valid, input, NUM_CONSUMERS, per-consumer read request.
REQ-007 SHALL have port consumer_read_address, input, NUM_CONSUMERS x ADDR_BITS, per-consumer read address.
REQ-008 SHALL have port consumer_read_ready, output, NUM_CONSUMERS, per-consumer read completion.
REQ-009 SHALL have port consumer_read_data, output, NUM_CONSUMERS x DATA_BITS, per-consumer returned read data.
REQ-010 SHALL have port consumer_write_valid, input, NUM_CONSUMERS, per-consumer write request.
REQ-011 SHALL have port consumer_write_address, input, NUM_CONSUMERS x ADDR_BITS, per-consumer write address.
REQ-012 SHALL have port consumer_write_data, input, NUM_CONSUMERS x DATA_BITS, per-consumer write data.
REQ-013 SHALL have port consumer_write_ready, output, NUM_CONSUMERS, per-consumer write completion.
REQ-014 SHALL have ports mem_read_valid (output, 1), mem_read_address (output, ADDR_BITS), mem_read_ready (input, 1), mem_read_data (input, DATA_BITS): downstream read channel.
REQ-015 SHALL have ports mem_write_valid (output, 1), mem_write_address (output, ADDR_BITS), mem_write_data (output, DATA_BITS), mem_write_ready (input, 1): downstream write channel.

Function
REQ-016 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, RELAY; exactly one downstream transaction outstanding at any time.
REQ-017 SHALL treat consumer i as requesting when consumer_read_valid[i] | consumer_write_valid[i]; if both set, read is serviced first, write on a later grant.
REQ-018 SHALL, in IDLE, grant the first requesting consumer at or after round-robin pointer rr_ptr (wrapping NUM_CONSUMERS-1 -> 0); with no requester, stay IDLE.
REQ-019 SHALL, on grant, latch consumer index, op type, address and write data into registers, and set rr_ptr = (granted index + 1) mod NUM_CONSUMERS.
REQ-020 SHALL assert mem_read_valid (READ_WAIT) or mem_write_valid (WRITE_WAIT) with latched address/data starting the cycle after the grant edge (1-cycle request latency), held until mem_*_ready sampled high.
REQ-021 SHALL, on mem_read_ready==1 in READ_WAIT, capture mem_read_data, deassert mem_read_valid, enter RELAY; likewise mem_write_ready in WRITE_WAIT.
REQ-022 SHALL, in RELAY, assert consumer_read_ready (or consumer_write_ready) only for the granted index, with consumer_read_data[granted] = captured data, held until that consumer's corresponding valid is sampled low, then return to IDLE and drop ready the same edge.
REQ-023 SHALL drive consumer_read_data for non-granted indices to 0 and hold captured data for the granted index only during RELAY.
REQ-024 SHALL ignore address/data changes from the granted consumer after the grant edge (latched values used).
REQ-025 SHALL not re-grant the same request: a consumer still holding valid in the IDLE cycle after RELAY is treated as a new request subject to rr_ptr.
REQ-026 SHALL never assert mem_read_valid and mem_write_valid simultaneously, nor more than one consumer ready bit.
REQ-027 SHALL ignore mem_*_ready outside its WAIT state.

Reset
REQ-028 SHALL, while reset==0 at a clk edge, force state=IDLE, rr_ptr=0, all latched registers 0, all outputs 0, including mid-transaction (outstanding downstream request abandoned).
REQ-029 SHALL accept a new grant on the first edge where reset==1 is sampled.

Verification
REQ-030 Single read: reset, consumer 2 read addr 0x40, mem_read_ready after 3 cycles with data 0xA5 -> mem_read_valid/addr 0x40 one cycle after request; consumer_read_ready[2]=1, data 0xA5 until read_valid[2] drops.
REQ-031 Round-robin: all 4 consumers read-valid from reset -> grant order 0,1,2,3,0; no consumer starved.
REQ-032 Read+write same consumer: consumer 1 read 0x10 and write 0x20/0x7E simultaneously -> read serviced first, then write with mem_write_address 0x20, mem_write_data 0x7E.
REQ-033 Reset mid-operation: reset low during READ_WAIT -> next cycle all outputs 0, state IDLE, rr_ptr 0; late mem_read_ready ignored.
REQ-034 Wrap-around: rr_ptr=3, requests from consumers 0 and 2 -> consumer 0 granted, rr_ptr becomes 1.
REQ-035 Exclusivity check: assertion throughout random traffic that at most one of mem_read_valid/mem_write_valid and at most one consumer ready bit is high.
